cic_ctrl: RTL and testbench

- Sequencing and configuration controller for the 2-stage CIC decimator in the AM SDR receive chain.
- Generates the CIC input sample tick from a programmable clock divider and applies runtime decimation/divider changes safely.
- Soft-resets the CIC on each reconfiguration and discards comb-settling outputs.
- Buffers decimated samples into a 2-entry valid/ready output queue for the demodulator.

---
 rtl/cic_pkg.sv | 36 +++
 rtl/cic_ctrl_fifo2.sv | 65 ++++++
 rtl/cic_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cic_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimator controller.
package cic_pkg;

  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned CFG_W         = 8;
  localparam int unsigned GAIN_W        = 3;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned WIDE_W        = SAMPLE_W + 8;

  localparam int unsigned DIV_DEFAULT   = 4;
  localparam int unsigned DECIM_DEFAULT = 64;
  localparam int unsigned DECIM_MIN     = 2;
  localparam int unsigned SETTLE_CNT    = 2;
  localparam int unsigned RST_CYCLES    = 2;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {SOFTRST, SETTLE, RUN} state_e;

  // Left shift with signed saturation to the sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_shift(
    input logic signed [SAMPLE_W-1:0] x,
    input logic        [GAIN_W-1:0]   sh
  );
    logic signed [WIDE_W-1:0] w;
    w = WIDE_W'(x) <<< sh;
    if (w > WIDE_W'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (w < WIDE_W'(SAT_MIN)) begin
      return SAT_MIN;
    end
    return SAMPLE_W'(w);
  endfunction

endpackage

// File: rtl/cic_ctrl_fifo2.sv
// Two-entry valid/ready queue; head entry drives the registered outputs.
module cic_ctrl_fifo2
  import cic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  input  logic                i_push,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_full_c,
  output logic                o_empty_c,
  output logic                o_drop_c
);

  logic                r_head_valid;
  logic [SAMPLE_W-1:0] r_head_data;
  logic                r_tail_valid;
  logic [SAMPLE_W-1:0] r_tail_data;
  logic                w_pop;

  assign w_pop     = r_head_valid && i_ready;
  assign o_full_c  = r_tail_valid;
  assign o_empty_c = !r_head_valid;
  assign o_drop_c  = i_push && r_tail_valid && !w_pop && !i_flush;
  assign o_valid   = r_head_valid;
  assign o_data    = r_head_data;

  // Head/tail shift register with simultaneous push/pop and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
      r_tail_valid <= 1'b0;
      r_tail_data  <= '0;
    end else if (i_flush) begin
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_valid) begin
        r_head_data <= r_tail_data;
        if (i_push) begin
          r_tail_data <= i_data;
        end else begin
          r_tail_valid <= 1'b0;
        end
      end else if (i_push) begin
        r_head_data <= i_data;
      end else begin
        r_head_valid <= 1'b0;
      end
    end else if (i_push) begin
      if (!r_head_valid) begin
        r_head_valid <= 1'b1;
        r_head_data  <= i_data;
      end else if (!r_tail_valid) begin
        r_tail_valid <= 1'b1;
        r_tail_data  <= i_data;
      end
    end
  end

endmodule

// File: rtl/cic_ctrl.sv
// CIC decimator sequencing/config controller: tick divider, soft reset,
// settle discard and output queue. Optional gain stage: CIC_CTRL_GAIN_EN.
module cic_ctrl
  import cic_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTb,
  input  logic [CFG_W-1:0]    cfg_div,
  input  logic [CFG_W-1:0]    cfg_decim,
  input  logic [GAIN_W-1:0]   cfg_gain,
  input  logic                cfg_load,
  output logic                cfg_busy,
  output logic                cic_rstb,
  output logic                cic_in_tick,
  output logic [CFG_W-1:0]    cic_decim,
  input  logic                cic_out_tick,
  input  logic [SAMPLE_W-1:0] cic_x_out,
  output logic                m_valid,
  output logic [SAMPLE_W-1:0] m_data,
  input  logic                m_ready,
  output logic                ovf,
  input  logic                ovf_clr
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CFG_W-1:0]    r_div;
  logic [CFG_W-1:0]    r_div_cnt;
  logic [CFG_W-1:0]    w_div_cnt_nxt;
  logic [CFG_W-1:0]    r_decim;
  logic                r_cic_rstb;
  logic                r_in_tick;
  logic                r_busy;
  logic                r_ovf;
  logic                w_accept;
  logic                w_push;
  logic [SAMPLE_W-1:0] w_push_data;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic                w_unused;

  assign cfg_busy    = r_busy;
  assign cic_rstb    = r_cic_rstb;
  assign cic_in_tick = r_in_tick;
  assign cic_decim   = r_decim;
  assign ovf         = r_ovf;

  // Next state; a reload restarts soft reset from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (cfg_load) begin
      w_state_nxt = SOFTRST;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        SOFTRST: begin
          if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cic_out_tick) begin
            if (r_cnt == CNT_W'(SETTLE_CNT - 1)) begin
              w_state_nxt = RUN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          w_accept = cic_out_tick;
        end
        default: begin
          w_state_nxt = SOFTRST;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Divider counter is parked at zero through soft reset.
  always_comb begin
    w_div_cnt_nxt = '0;
    if ((r_state != SOFTRST) && (w_state_nxt != SOFTRST) &&
        (r_div_cnt < r_div - CFG_W'(1))) begin
      w_div_cnt_nxt = r_div_cnt + CFG_W'(1);
    end
  end

  // State, counters and registered control outputs.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state    <= SOFTRST;
      r_cnt      <= '0;
      r_div_cnt  <= '0;
      r_cic_rstb <= 1'b0;
      r_in_tick  <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_cic_rstb <= (w_state_nxt != SOFTRST);
      r_in_tick  <= (w_state_nxt != SOFTRST) && (w_div_cnt_nxt == r_div - CFG_W'(1));
      r_busy     <= (w_state_nxt != RUN);
    end
  end

  // Latch clamped configuration on reload.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_div   <= CFG_W'(DIV_DEFAULT);
      r_decim <= CFG_W'(DECIM_DEFAULT);
    end else if (cfg_load) begin
      r_div   <= (cfg_div == '0) ? CFG_W'(1) : cfg_div;
      r_decim <= (cfg_decim < CFG_W'(DECIM_MIN)) ? CFG_W'(DECIM_MIN) : cfg_decim;
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef CIC_CTRL_GAIN_EN
  logic [GAIN_W-1:0]   r_gain;
  logic                r_gs_valid;
  logic [SAMPLE_W-1:0] r_gs_data;

  // Gain stage: saturating shift, dropped on reload.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_gain     <= '0;
      r_gs_valid <= 1'b0;
      r_gs_data  <= '0;
    end else if (cfg_load) begin
      r_gain     <= cfg_gain;
      r_gs_valid <= 1'b0;
    end else begin
      r_gs_valid <= w_accept;
      if (w_accept) begin
        r_gs_data <= sat_shift(cic_x_out, r_gain);
      end
    end
  end

  assign w_push      = r_gs_valid && !cfg_load;
  assign w_push_data = r_gs_data;
  assign w_unused    = &{1'b0, w_full, w_empty};
`else
  assign w_push      = w_accept;
  assign w_push_data = cic_x_out;
  assign w_unused    = &{1'b0, w_full, w_empty, cfg_gain};
`endif

  cic_ctrl_fifo2 u_fifo (
    .clk       (CLK),
    .rst_n     (RSTb),
    .i_flush   (cfg_load),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .i_ready   (m_ready),
    .o_valid   (m_valid),
    .o_data    (m_data),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_drop_c  (w_drop)
  );

endmodule

// File: tb/tb_cic_ctrl.sv
// Self-checking bench for cic_ctrl; output samples checked against a queue.
module tb_cic_ctrl;

`ifdef CIC_CTRL_GAIN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [7:0]  cfg_div = 8'd0;
  logic [7:0]  cfg_decim = 8'd0;
  logic [2:0]  cfg_gain = 3'd0;
  logic        cfg_load = 1'b0;
  logic        cfg_busy;
  logic        cic_rstb;
  logic        cic_in_tick;
  logic [7:0]  cic_decim;
  logic        cic_out_tick = 1'b0;
  logic [15:0] cic_x_out = 16'd0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  cic_ctrl dut (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .cfg_div      (cfg_div),
    .cfg_decim    (cfg_decim),
    .cfg_gain     (cfg_gain),
    .cfg_load     (cfg_load),
    .cfg_busy     (cfg_busy),
    .cic_rstb     (cic_rstb),
    .cic_in_tick  (cic_in_tick),
    .cic_decim    (cic_decim),
    .cic_out_tick (cic_out_tick),
    .cic_x_out    (cic_x_out),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every accepted output must match the oldest expected sample.
  always @(negedge CLK) begin
    if (RSTb && m_valid && m_ready) begin
      n_total = n_total + 1;
      if (sb.size() == 0) begin
        $display("FAIL out_unexpected: got %h, required no output", m_data);
      end else begin
        mon_exp = sb.pop_front();
        if (m_data !== mon_exp) begin
          $display("FAIL out_data: got %h, required %h", m_data, mon_exp);
        end else begin
          n_pass = n_pass + 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef CIC_CTRL_GAIN_EN
  function automatic logic [15:0] gain_model(input logic [15:0] x, input int g);
    int v;
    v = int'($signed(x)) * (1 << g);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 16'(v);
  endfunction
`endif

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d, input logic [7:0] dec, input logic [2:0] g);
    cfg_div   = d;
    cfg_decim = dec;
    cfg_gain  = g;
    cfg_load  = 1'b1;
    sb.delete();
    step();
    cfg_load  = 1'b0;
  endtask

  task automatic go_run(input logic [7:0] d, input logic [7:0] dec, input logic [2:0] g);
    do_load(d, dec, g);
    step();
    step();
    cic_x_out    = 16'hDEAD;
    cic_out_tick = 1'b1;
    step();
    step();
    cic_out_tick = 1'b0;
  endtask

  task automatic drive_sample(input logic [15:0] v);
    cic_x_out    = v;
    cic_out_tick = 1'b1;
    step();
    cic_out_tick = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    RSTb    = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();
    n_total++;
    if ({cic_rstb, cfg_busy, m_valid, ovf, cic_in_tick} !== 5'b01000)
      $display("FAIL reset_flags: got %b, required %b",
               {cic_rstb, cfg_busy, m_valid, ovf, cic_in_tick}, 5'b01000);
    else n_pass++;
    n_total++;
    if (m_data !== 16'h0000) $display("FAIL reset_mdata: got %h, required 0000", m_data);
    else n_pass++;
    n_total++;
    if (cic_decim !== 8'd64) $display("FAIL reset_decim: got %0d, required 64", cic_decim);
    else n_pass++;

    RSTb = 1'b1;
    step();
    n_total++;
    if (cic_rstb !== 1'b0) $display("FAIL softrst_hold: got %b, required 0", cic_rstb);
    else n_pass++;
    step();
    n_total++;
    if ({cic_rstb, cfg_busy} !== 2'b11)
      $display("FAIL softrst_release: got %b, required 11", {cic_rstb, cfg_busy});
    else n_pass++;

    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      n_total++;
      if (cic_in_tick !== ((i % 4) == 3))
        $display("FAIL div4_tick[%0d]: got %b, required %b", i, cic_in_tick, (i % 4) == 3);
      else n_pass++;
    end

    drive_sample(16'h0011);
    step();
    drive_sample(16'h0022);
    n_total++;
    if ({cfg_busy, m_valid} !== 2'b00)
      $display("FAIL settle_to_run: got busy/valid %b, required 00", {cfg_busy, m_valid});
    else n_pass++;

    sb.push_back(16'h0033);
    drive_sample(16'h0033);
    repeat (LAT - 1) step();
    n_total++;
    if ({m_valid, m_data} !== {1'b1, 16'h0033})
      $display("FAIL first_sample: got %b/%h, required 1/0033", m_valid, m_data);
    else n_pass++;
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL reset_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_clamp();
    do_load(8'd0, 8'd1, 3'd0);
    n_total++;
    if ({cic_decim, cic_rstb, cic_in_tick} !== {8'd2, 1'b0, 1'b0})
      $display("FAIL clamp_load: got decim %0d rstb %b tick %b, required 2 0 0",
               cic_decim, cic_rstb, cic_in_tick);
    else n_pass++;
    step();
    n_total++;
    if (cic_in_tick !== 1'b0) $display("FAIL clamp_softrst_tick: got %b, required 0", cic_in_tick);
    else n_pass++;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      n_total++;
      if ({cic_rstb, cic_in_tick} !== 2'b11)
        $display("FAIL div1_tick[%0d]: got %b, required 11", i, {cic_rstb, cic_in_tick});
      else n_pass++;
    end
    cic_out_tick = 1'b1;
    step();
    step();
    cic_out_tick = 1'b0;
    n_total++;
    if (cfg_busy !== 1'b0) $display("FAIL clamp_run: got busy %b, required 0", cfg_busy);
    else n_pass++;
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    sb.push_back(16'h0100);
    drive_sample(16'h0100);
    sb.push_back(16'h0200);
    drive_sample(16'h0200);
    drive_sample(16'h0300);
    repeat (LAT - 1) step();
    n_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_set: got %b, required 1", ovf);
    else n_pass++;
    step();
    step();
    n_total++;
    if ({m_valid, m_data} !== {1'b1, 16'h0100})
      $display("FAIL hold_stable: got %b/%h, required 1/0100", m_valid, m_data);
    else n_pass++;
    m_ready = 1'b1;
    step();
    n_total++;
    if ({m_valid, m_data} !== {1'b1, 16'h0200})
      $display("FAIL pop_first: got %b/%h, required 1/0200", m_valid, m_data);
    else n_pass++;
    step();
    n_total++;
    if ({m_valid, ovf} !== 2'b01)
      $display("FAIL pop_second: got valid/ovf %b, required 01", {m_valid, ovf});
    else n_pass++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_total++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", ovf);
    else n_pass++;
  endtask

  task automatic test_push_pop_full();
    bit ok;
    m_ready = 1'b0;
    sb.push_back(16'h0100);
    drive_sample(16'h0100);
    sb.push_back(16'h0200);
    drive_sample(16'h0200);
    sb.push_back(16'h0400);
`ifdef CIC_CTRL_GAIN_EN
    drive_sample(16'h0400);
    m_ready = 1'b1;
    step();
`else
    m_ready = 1'b1;
    drive_sample(16'h0400);
`endif
    n_total++;
    if ({ovf, m_valid, m_data} !== {1'b0, 1'b1, 16'h0200})
      $display("FAIL full_push_pop: got ovf %b %b/%h, required 0 1/0200", ovf, m_valid, m_data);
    else n_pass++;
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL full_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_ovf_priority();
    bit ok;
    m_ready = 1'b0;
    sb.push_back(16'h0501);
    drive_sample(16'h0501);
    sb.push_back(16'h0502);
    drive_sample(16'h0502);
`ifdef CIC_CTRL_GAIN_EN
    drive_sample(16'h0503);
    ovf_clr = 1'b1;
    step();
`else
    ovf_clr = 1'b1;
    drive_sample(16'h0503);
`endif
    ovf_clr = 1'b0;
    n_total++;
    if (ovf !== 1'b1) $display("FAIL drop_beats_clr: got %b, required 1", ovf);
    else n_pass++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_total++;
    if (ovf !== 1'b0) $display("FAIL clr_alone: got %b, required 0", ovf);
    else n_pass++;
    m_ready = 1'b1;
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL prio_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reload();
    do_load(8'd4, 8'd10, 3'd0);
    n_total++;
    if ({cic_decim, cic_rstb} !== {8'd10, 1'b0})
      $display("FAIL reload_cfg: got decim %0d rstb %b, required 10 0", cic_decim, cic_rstb);
    else n_pass++;
    cic_x_out    = 16'h0BAD;
    cic_out_tick = 1'b1;
    step();
    do_load(8'd4, 8'd10, 3'd0);
    n_total++;
    if (cic_rstb !== 1'b0) $display("FAIL reload_restart: got %b, required 0", cic_rstb);
    else n_pass++;
    step();
    n_total++;
    if (cic_rstb !== 1'b0) $display("FAIL reload_hold: got %b, required 0", cic_rstb);
    else n_pass++;
    step();
    cic_out_tick = 1'b0;
    n_total++;
    if (cic_rstb !== 1'b1) $display("FAIL reload_release: got %b, required 1", cic_rstb);
    else n_pass++;
    drive_sample(16'h0BAD);
    n_total++;
    if (cfg_busy !== 1'b1) $display("FAIL softrst_tick_ignored: got busy %b, required 1", cfg_busy);
    else n_pass++;
    drive_sample(16'h0BAD);
    n_total++;
    if (cfg_busy !== 1'b0) $display("FAIL reload_run: got busy %b, required 0", cfg_busy);
    else n_pass++;

    m_ready = 1'b0;
    sb.push_back(16'h0AAA);
    drive_sample(16'h0AAA);
    repeat (LAT - 1) step();
    n_total++;
    if (m_valid !== 1'b1) $display("FAIL reload_queued: got %b, required 1", m_valid);
    else n_pass++;
    do_load(8'd4, 8'd10, 3'd0);
    n_total++;
    if (m_valid !== 1'b0) $display("FAIL flush_valid: got %b, required 0", m_valid);
    else n_pass++;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (m_valid !== 1'b0) $display("FAIL flush_stays[%0d]: got %b, required 0", i, m_valid);
      else n_pass++;
    end
  endtask

  task automatic test_gain();
    bit ok;
    logic [15:0] vin [4];
    logic [15:0] vexp;
    vin[0] = 16'h0123;
    vin[1] = 16'h1000;
    vin[2] = 16'hF000;
    vin[3] = 16'hFFF0;
    go_run(8'd4, 8'd64, 3'd4);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef CIC_CTRL_GAIN_EN
      vexp = gain_model(vin[i], 4);
`else
      vexp = vin[i];
`endif
      sb.push_back(vexp);
      drive_sample(vin[i]);
    end
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL gain_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_overflow();
    test_push_pop_full();
    test_ovf_priority();
    test_reload();
    test_gain();
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
